// File: rtl/fir_pkg.sv
// Shared sample-width definitions for the FIR datapath (fir_filter and its
// downstream stages). Widths here are the defaults; blocks may override them.
package fir_pkg;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;

    typedef logic signed [IN_W-1:0]  in_sample_t;
    typedef logic signed [OUT_W-1:0] out_sample_t;

    // Clamp limits for an OUT_W-bit signed result.
    localparam out_sample_t OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam out_sample_t OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

endpackage : fir_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage. The head entry is read straight
// from the storage array, so rd_data is valid whenever empty is low.
// A write while full only succeeds if a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    // Qualify requests: reads need data, writes need room (or a same-cycle read).
    always_comb begin
        do_rd = rd_en && !empty;
        do_wr = wr_en && (!full || do_rd);
    end

    // Storage array and pointers.
    // NOTE: the array is reset because it is only DEPTH entries deep and the
    // head must read as zero straight out of reset; large FIFOs should not do this.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy count, 0..DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Status flags and head data.
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        rd_data = mem[rd_ptr];
    end

endmodule : sync_fifo

// File: rtl/fir_output_decimator.sv
// Output stage after fir_filter: keeps one sample in every DECIM, rounds off
// SHIFT fraction bits (ties toward +inf), saturates to OUT_W bits and queues
// results in a small FIFO with a valid/ready interface. Sticky flags report
// saturation and samples lost to a full FIFO.
module fir_output_decimator #(
    parameter int DECIM = 4,
    parameter int SHIFT = 8,
    parameter int IN_W  = fir_pkg::IN_W,
    parameter int OUT_W = fir_pkg::OUT_W,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  y_in,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_flag,
    output logic                    overflow
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    // Rounding and clamp constants, all in the IN_W+1 bit working width.
    localparam logic signed [IN_W:0] RND    = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] SAT_HI = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_LO = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [PW-1:0]           phase;
    logic                    last_phase;
    logic                    keep;

    logic signed [IN_W:0]    y_ext;
    logic signed [IN_W:0]    rounded;
    logic signed [OUT_W-1:0] sat_val;
    logic                    clamp;

    logic                    pend;
    logic signed [OUT_W-1:0] pend_data;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    rd_en;
    logic                    drop;

    // Decide whether the current input sample is the one kept this period.
    always_comb begin
        last_phase = (phase == PW'(DECIM - 1));
        keep       = in_valid && last_phase;
    end

    // Phase counter: advances only on valid samples, wraps after DECIM-1.
    // NOTE: sequential state is always updated with <= so every flop samples
    // its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (in_valid) begin
            phase <= last_phase ? '0 : phase + 1'b1;
        end
    end

    // Round to nearest (ties to +inf) with one guard bit, then clamp to OUT_W.
    // NOTE: every output of this block gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        y_ext   = {y_in[IN_W-1], y_in};
        rounded = (y_ext + RND) >>> SHIFT;
        clamp   = 1'b0;
        sat_val = rounded[OUT_W-1:0];
        if (rounded > SAT_HI) begin
            clamp   = 1'b1;
            sat_val = SAT_HI[OUT_W-1:0];
        end else if (rounded < SAT_LO) begin
            clamp   = 1'b1;
            sat_val = SAT_LO[OUT_W-1:0];
        end
    end

    // Pipeline register between the rounding logic and the FIFO write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_data <= '0;
        end else begin
            pend <= keep;
            if (keep) begin
                pend_data <= sat_val;
            end
        end
    end

    // Handshake: a pop happens when the consumer takes a valid head entry.
    // A pending write is lost only when the FIFO is full and nothing pops.
    always_comb begin
        out_valid = !fifo_empty;
        rd_en     = out_valid && out_ready;
        drop      = pend && fifo_full && !rd_en;
    end

    // Sticky status flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (keep && clamp) begin
                sat_flag <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pend),
        .wr_data (pend_data),
        .rd_en   (rd_en),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule : fir_output_decimator

// File: doc/fir_output_decimator.md
# fir_output_decimator

Downstream stage of `fir_filter`: consumes the 32-bit signed filter output every accepted cycle, keeps one sample in every DECIM, rounds and saturates it to 16-bit signed, and buffers results in a small FIFO with a valid/ready output. It converts the full-precision, full-rate FIR result into a reduced-rate, reduced-width stream for the next consumer, and flags saturation and data loss.

## Interface
- `DECIM`, 4: decimation factor, ≥1; the sample at phase DECIM-1 is kept.
- `SHIFT`, 8: fraction bits dropped by rounding, 1..24.
- `IN_W`, 32: input width; matches `fir_filter` `y_out`.
- `OUT_W`, 16: output width.
- `DEPTH`, 4: FIFO depth, power of two ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `y_in` valid this cycle; tie high when driven directly by `fir_filter`.
- `y_in`  in  IN_W signed  filter output sample.
- `out_data`  out  OUT_W signed  FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid && out_ready`.
- `sat_flag`  out  1  sticky: at least one kept sample was saturated.
- `overflow`  out  1  sticky: at least one kept sample was dropped because the FIFO was full.

## Operation
- Phase counter 0..DECIM-1 advances on each `in_valid` and wraps from DECIM-1 to 0; it holds when `in_valid`=0.
- Sample kept when `in_valid` && phase==DECIM-1; with DECIM=1 every valid sample is kept.
- Rounding: computed in IN_W+1 bits as (y_in + 2^(SHIFT-1)) >>> SHIFT, using an arithmetic shift, so ties round toward +inf.
- Saturation: rounded value clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; on clamp, `sat_flag` is set.
- Pipeline stage: a kept sample's rounded/saturated value plus a `pend` bit are registered at the accepting edge.
- FIFO write occurs on the next edge when `pend`=1.
- If the FIFO is full and there is no read in the same cycle, the write is dropped and `overflow` is set. The FIFO contents are unchanged.
- Simultaneous read and write when full: both succeed, count unchanged.
- Simultaneous read and write when empty: write succeeds; the read cannot occur because `out_valid`=0.
- FIFO order is strict first-in first-out. Pointers wrap modulo DEPTH, and count ranges 0..DEPTH.
- Sticky flags clear only on `rst`.

## Timing
- Reset values: phase 0, `pend` 0, FIFO empty, `out_valid` 0, `out_data` 0, `sat_flag` 0, `overflow` 0.
- Latency: kept sample at edge k → `pend` after k → FIFO write at k+1 → `out_valid`=1 and `out_data` valid after edge k+1 when the FIFO was empty.
- `sat_flag` is set at edge k, the same edge the pipeline register loads.
- `overflow` is set at edge k+1, the same edge as the dropped write.
- `out_data` is held stable while `out_valid && !out_ready`.
- After a pop, the next entry appears the following cycle.
- Throughput: one output per cycle, sustained only when DECIM=1 and `out_ready`=1.
- `rst` asserted mid-operation: the pending pipeline sample and the FIFO contents are discarded, and all outputs return to reset values after that edge.

## Structure
- Shared package `fir_pkg`: `IN_W`/`OUT_W` sample widths, signed sample typedefs, and OUT_W min/max saturation constants; also used by `fir_filter`.
- Sub-module `sync_fifo`:
  - Parameters: width, DEPTH.
  - Ports: `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`.
  - Read data is taken from the registered head.
- Top level contains the phase counter, round/saturate logic, pipeline register, and sticky flags.

## Test plan
- Ramp with DECIM=4, SHIFT=8, `out_ready`=1: inputs 256, 512, 768, 1024 → a single output 4 at 2 edges after 1024 is accepted. The next ramp 1280..2048 → output 8.
- Rounding: kept inputs 384 → 2, 383 → 1, -384 → -1, -385 → -2. `sat_flag` stays 0.
- Saturation: kept 0x7FFFFFFF → 32767 and kept 0x80000000 → -32768. `sat_flag`=1 after the first and stays 1 until `rst`.
- Backpressure: `out_ready`=0 with kept values 1..5 → FIFO holds 1..4 and 5 is dropped with `overflow`=1. After `out_ready`=1, outputs 1, 2, 3, 4 appear on consecutive cycles, then `out_valid`=0.
- Gapped `in_valid`: valid on alternating cycles with DECIM=4 → one output per 4 valid samples, and the phase does not advance on idle cycles.
- Reset mid-operation: `rst` pulsed with 2 entries in the FIFO and `pend`=1 → `out_valid`=0 and the flags are 0 after the edge. The next kept sample needs a full DECIM samples from phase 0.
